// File: rtl/axi_b_snoop_fifo.sv
// rtl/axi_b_snoop_fifo.sv - AXI4 B-channel passthrough with buffered response capture to a stream
//
// Optional feature macro: AXIB_SNOOP_DROP_CNT_EN (adds drop_count / overflow outputs)
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ready                           stream sink accepts the current word
//   valid, last, data               head-of-FIFO stream word (single beat, last == valid)
//   in_progress                     tied 0 (single-beat transfers)
//   submodule_transaction_length    tied 1
//   level                           current FIFO occupancy
//   AXIM_b*  <-> AXIS_b*            B channel, master side in / slave side out
//   drop_count, overflow            drop statistics (only with AXIB_SNOOP_DROP_CNT_EN)
module axi_b_snoop_fifo #(
  parameter int DATA_WIDTH        = 128,
  parameter int ID_WIDTH          = 32,
  parameter int USER_WIDTH        = 64,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = 3'b100,
  parameter int FIFO_DEPTH        = 4,
  parameter int BLOCK_ON_FULL     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ready,
  output logic                             valid,
  output logic                             in_progress,
  output logic                             last,
  output logic [DATA_WIDTH-1:0]            data,
  output logic [5:0]                       submodule_transaction_length,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
  output logic [ID_WIDTH-1:0]              AXIS_bid,
  output logic [1:0]                       AXIS_bresp,
  output logic [USER_WIDTH-1:0]            AXIS_buser,
  output logic                             AXIS_bvalid,
  input  logic                             AXIS_bready,
  input  logic [ID_WIDTH-1:0]              AXIM_bid,
  input  logic [1:0]                       AXIM_bresp,
  input  logic [USER_WIDTH-1:0]            AXIM_buser,
  input  logic                             AXIM_bvalid,
  output logic                             AXIM_bready
`ifdef AXIB_SNOOP_DROP_CNT_EN
  ,
  output logic [15:0]                      drop_count,
  output logic                             overflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int EW = ID_WIDTH + 2;

  if (DATA_WIDTH < STREAM_TYPE_WIDTH + ID_WIDTH + 2) begin : g_bad_data_width
    $error("axi_b_snoop_fifo: DATA_WIDTH too small for {STREAM_TYPE, bid, bresp}");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi_b_snoop_fifo: FIFO_DEPTH must be a power of two in 2..64");
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          gate;
  logic          hs;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // full comes from registered occupancy only, so a same-cycle pop never frees room for a push
  assign full = (count == LW'(FIFO_DEPTH));

  // In blocking mode the B handshake is held off while full; reset forces the path open
  assign gate = (BLOCK_ON_FULL != 0) ? (reset | ~full) : 1'b1;

  assign AXIS_bid    = AXIM_bid;
  assign AXIS_bresp  = AXIM_bresp;
  assign AXIS_buser  = AXIM_buser;
  assign AXIS_bvalid = AXIM_bvalid & gate;
  assign AXIM_bready = AXIS_bready & gate;

  assign hs   = ~reset & AXIM_bvalid & AXIS_bready & gate;
  // In drop mode hs while full completes on the bus but stores nothing
  assign push = hs & ~full;

  assign valid = (count != '0);
  assign pop   = valid & ready;
  assign head  = mem[rd_ptr];

  assign in_progress                  = 1'b0;
  assign last                         = valid;
  assign submodule_transaction_length = 6'd1;
  assign level                        = count;

  always_comb begin
    data = '0;
    data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH]            = STREAM_TYPE;
    data[DATA_WIDTH-STREAM_TYPE_WIDTH-1 -: ID_WIDTH]   = head[EW-1:2];
    data[1:0]                                          = head[1:0];
  end

  // Storage carries no reset; stale entries are unreachable once count is cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {AXIM_bid, AXIM_bresp};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push) - LW'(pop);
    end
  end

`ifdef AXIB_SNOOP_DROP_CNT_EN
  logic drop;
  // Never true in blocking mode because gate already excludes full
  assign drop = hs & full;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_b_snoop_fifo.sv
// tb/tb_axi_b_snoop_fifo.sv - self-checking bench for axi_b_snoop_fifo (blocking and dropping instances)
module tb_axi_b_snoop_fifo;

  logic        clk;
  logic        rst;
  logic        bv    [2];
  logic        br    [2];
  logic        rdy   [2];
  logic [31:0] bid   [2];
  logic [1:0]  bresp [2];
  logic [63:0] buser [2];

  logic         o_valid  [2];
  logic         o_inp    [2];
  logic         o_last   [2];
  logic [127:0] o_data   [2];
  logic [5:0]   o_stl    [2];
  logic [2:0]   o_level  [2];
  logic [31:0]  o_bid    [2];
  logic [1:0]   o_bresp  [2];
  logic [63:0]  o_buser  [2];
  logic         o_bvalid [2];
  logic         o_bready [2];
`ifdef AXIB_SNOOP_DROP_CNT_EN
  logic [15:0]  o_drop   [2];
  logic         o_ovf    [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  axi_b_snoop_fifo #(.FIFO_DEPTH(4), .BLOCK_ON_FULL(1)) u_blk (
    .clk(clk), .reset(rst), .ready(rdy[0]), .valid(o_valid[0]), .in_progress(o_inp[0]),
    .last(o_last[0]), .data(o_data[0]), .submodule_transaction_length(o_stl[0]), .level(o_level[0]),
    .AXIS_bid(o_bid[0]), .AXIS_bresp(o_bresp[0]), .AXIS_buser(o_buser[0]), .AXIS_bvalid(o_bvalid[0]),
    .AXIS_bready(br[0]), .AXIM_bid(bid[0]), .AXIM_bresp(bresp[0]), .AXIM_buser(buser[0]),
    .AXIM_bvalid(bv[0]), .AXIM_bready(o_bready[0])
`ifdef AXIB_SNOOP_DROP_CNT_EN
    , .drop_count(o_drop[0]), .overflow(o_ovf[0])
`endif
  );

  axi_b_snoop_fifo #(.FIFO_DEPTH(4), .BLOCK_ON_FULL(0)) u_drop (
    .clk(clk), .reset(rst), .ready(rdy[1]), .valid(o_valid[1]), .in_progress(o_inp[1]),
    .last(o_last[1]), .data(o_data[1]), .submodule_transaction_length(o_stl[1]), .level(o_level[1]),
    .AXIS_bid(o_bid[1]), .AXIS_bresp(o_bresp[1]), .AXIS_buser(o_buser[1]), .AXIS_bvalid(o_bvalid[1]),
    .AXIS_bready(br[1]), .AXIM_bid(bid[1]), .AXIM_bresp(bresp[1]), .AXIM_buser(buser[1]),
    .AXIM_bvalid(bv[1]), .AXIM_bready(o_bready[1])
`ifdef AXIB_SNOOP_DROP_CNT_EN
    , .drop_count(o_drop[1]), .overflow(o_ovf[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Reference model: one queue of {bid, bresp} per instance plus a drop tally
  logic [33:0] q0 [$];
  logic [33:0] q1 [$];
  int          drops [2];
  logic        m_hs  [2];
  logic        m_pop [2];

  function automatic int msize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [33:0] mhead(input int d);
    if (msize(d) == 0) return '0;
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic chk(input int d, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Compare every output against the model at the falling edge, then advance the model
  task automatic check_model();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int           sz;
      logic         full;
      logic         gate;
      logic [33:0]  h;
      logic [127:0] ed;
      sz   = msize(d);
      full = (sz == 4);
      gate = (d == 0) ? (rst | !full) : 1'b1;
      h    = mhead(d);
      ed   = (128'(3'b100) << 125) | (128'(h[33:2]) << 93) | 128'(h[1:0]);
      chk(d, "axis_bvalid", 128'(o_bvalid[d]), 128'(bv[d] & gate));
      chk(d, "axim_bready", 128'(o_bready[d]), 128'(br[d] & gate));
      chk(d, "bid_pass",    128'(o_bid[d]),    128'(bid[d]));
      chk(d, "bresp_pass",  128'(o_bresp[d]),  128'(bresp[d]));
      chk(d, "buser_pass",  128'(o_buser[d]),  128'(buser[d]));
      chk(d, "valid",       128'(o_valid[d]),  128'(sz > 0));
      chk(d, "last",        128'(o_last[d]),   128'(sz > 0));
      chk(d, "level",       128'(o_level[d]),  128'(sz));
      chk(d, "in_progress", 128'(o_inp[d]),    128'(0));
      chk(d, "stl",         128'(o_stl[d]),    128'(1));
      if (sz > 0) chk(d, "data", o_data[d], ed);
`ifdef AXIB_SNOOP_DROP_CNT_EN
      chk(d, "drop_count", 128'(o_drop[d]), 128'(drops[d]));
      chk(d, "overflow",   128'(o_ovf[d]),  128'(drops[d] > 0));
`endif
      m_hs[d]  = !rst && bv[d] && br[d] && gate;
      m_pop[d] = (sz > 0) && rdy[d];
      if (rst) begin
        if (d == 0) q0.delete(); else q1.delete();
        drops[d] = 0;
      end else begin
        if (m_pop[d]) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (m_hs[d]) begin
          if (!full) begin
            if (d == 0) q0.push_back({bid[d], bresp[d]}); else q1.push_back({bid[d], bresp[d]});
          end else if (drops[d] < 65535) begin
            drops[d]++;
          end
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    bv[d] = 1'b0; br[d] = 1'b0; rdy[d] = 1'b0;
    bid[d] = '0; bresp[d] = '0; buser[d] = '0;
  endtask

  typedef struct {
    logic        rst;
    logic        bv;
    logic [31:0] id;
    logic [1:0]  resp;
    logic        ready;
    logic        e_axis_bvalid;
    logic        e_axim_bready;
    logic        e_valid;
    logic [2:0]  e_level;
    logic [31:0] e_head;
    logic [1:0]  e_resp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input int id, input int resp, input logic rd,
                              input logic eb, input logic er, input logic ev, input int el,
                              input int eh, input int eresp);
    vec_t t;
    t.rst = r; t.bv = v; t.id = 32'(id); t.resp = 2'(resp); t.ready = rd;
    t.e_axis_bvalid = eb; t.e_axim_bready = er; t.e_valid = ev;
    t.e_level = 3'(el); t.e_head = 32'(eh); t.e_resp = 2'(eresp);
    return t;
  endfunction

  vec_t tbl [17];

  initial begin
    int idx;
    int got;

    // Blocking instance, AXIS_bready held 1: reset passthrough, single capture, fill/mask/drain
    tbl[0]  = mk(1, 1, 9, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 5, 2, 1,  1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1,  0, 1, 1, 1, 5, 2);
    tbl[3]  = mk(0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 2, 1, 0,  1, 1, 1, 1, 1, 1);
    tbl[6]  = mk(0, 1, 3, 1, 0,  1, 1, 1, 2, 1, 1);
    tbl[7]  = mk(0, 1, 4, 1, 0,  1, 1, 1, 3, 1, 1);
    tbl[8]  = mk(0, 1, 5, 1, 0,  0, 0, 1, 4, 1, 1);
    tbl[9]  = mk(0, 1, 5, 1, 1,  0, 0, 1, 4, 1, 1);
    tbl[10] = mk(0, 1, 5, 1, 0,  1, 1, 1, 3, 2, 1);
    tbl[11] = mk(0, 1, 6, 1, 1,  0, 0, 1, 4, 2, 1);
    tbl[12] = mk(0, 1, 6, 1, 1,  1, 1, 1, 3, 3, 1);
    tbl[13] = mk(0, 0, 0, 0, 1,  0, 1, 1, 3, 4, 1);
    tbl[14] = mk(0, 0, 0, 0, 1,  0, 1, 1, 2, 5, 1);
    tbl[15] = mk(0, 0, 0, 0, 1,  0, 1, 1, 1, 6, 1);
    tbl[16] = mk(0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);

    drops[0] = 0; drops[1] = 0;
    rst = 1'b1;
    idle(0); idle(1);
    advance();
    advance();

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      bv[0] = tbl[i].bv; bid[0] = tbl[i].id; bresp[0] = tbl[i].resp;
      br[0] = 1'b1; rdy[0] = tbl[i].ready; buser[0] = {32'hCAFE0000, tbl[i].id};
      check_model();
      chk(0, "tbl_axis_bvalid", 128'(o_bvalid[0]), 128'(tbl[i].e_axis_bvalid));
      chk(0, "tbl_axim_bready", 128'(o_bready[0]), 128'(tbl[i].e_axim_bready));
      chk(0, "tbl_valid",       128'(o_valid[0]),  128'(tbl[i].e_valid));
      chk(0, "tbl_level",       128'(o_level[0]),  128'(tbl[i].e_level));
      if (tbl[i].e_valid) begin
        chk(0, "tbl_head_id",   128'(o_data[0][124:93]), 128'(tbl[i].e_head));
        chk(0, "tbl_head_resp", 128'(o_data[0][1:0]),    128'(tbl[i].e_resp));
        chk(0, "tbl_type",      128'(o_data[0][127:125]), 128'(3'b100));
      end
      advance();
    end
    idle(0);

    // Dropping instance: 6 responses with the sink stalled, all complete, first 4 kept
    for (int i = 1; i <= 6; i++) begin
      bv[1] = 1'b1; br[1] = 1'b1; rdy[1] = 1'b0; bid[1] = 32'(i); bresp[1] = 2'(i);
      check_model();
      chk(1, "drop_hs_bready", 128'(o_bready[1]), 128'(1));
      chk(1, "drop_hs_bvalid", 128'(o_bvalid[1]), 128'(1));
      advance();
    end
    bv[1] = 1'b0;
    check_model();
    chk(1, "drop_level_full", 128'(o_level[1]), 128'(4));
`ifdef AXIB_SNOOP_DROP_CNT_EN
    chk(1, "drop_count_2", 128'(o_drop[1]), 128'(2));
    chk(1, "overflow_set", 128'(o_ovf[1]),  128'(1));
    chk(0, "blk_no_drops", 128'(o_drop[0]), 128'(0));
`endif
    advance();
    for (int i = 1; i <= 4; i++) begin
      rdy[1] = 1'b1;
      check_model();
      chk(1, "drop_drain_id", 128'(o_data[1][124:93]), 128'(i));
      advance();
    end
    check_model();
    chk(1, "drop_drained", 128'(o_valid[1]), 128'(0));
    advance();
    // Refill, then a response arrives while full with the sink ready: it is dropped
    for (int i = 11; i <= 14; i++) begin
      bv[1] = 1'b1; rdy[1] = 1'b0; bid[1] = 32'(i); bresp[1] = 2'(i);
      check_model();
      advance();
    end
    bv[1] = 1'b1; rdy[1] = 1'b1; bid[1] = 32'd77;
    check_model();
    chk(1, "full_drop_bready", 128'(o_bready[1]), 128'(1));
    advance();
    bv[1] = 1'b0; rdy[1] = 1'b0;
    check_model();
    chk(1, "full_drop_level", 128'(o_level[1]), 128'(3));
    chk(1, "full_drop_head",  128'(o_data[1][124:93]), 128'(12));
    advance();
    idle(1);

    // Blocking instance: 20 responses with the sink toggling every cycle, across pointer wrap
    idx = 0;
    got = 0;
    for (int c = 0; c < 300 && got < 20; c++) begin
      bv[0] = (idx < 20); br[0] = 1'b1; bid[0] = 32'(100 + idx); bresp[0] = 2'(idx);
      rdy[0] = c[0];
      check_model();
      if (m_pop[0]) begin
        chk(0, "wrap_order", 128'(o_data[0][124:93]), 128'(100 + got));
        got++;
      end
      if (m_hs[0]) idx++;
      advance();
    end
    chk(0, "wrap_count", 128'(got), 128'(20));
    idle(0);

    // Reset with three entries held: passthrough stays open, nothing captured
    for (int i = 21; i <= 23; i++) begin
      bv[0] = 1'b1; br[0] = 1'b1; rdy[0] = 1'b0; bid[0] = 32'(i);
      check_model();
      advance();
    end
    bv[0] = 1'b0;
    check_model();
    chk(0, "pre_reset_level", 128'(o_level[0]), 128'(3));
    advance();
    rst = 1'b1; bv[0] = 1'b1; br[0] = 1'b1; bid[0] = 32'd99;
    check_model();
    chk(0, "rst_axis_bvalid", 128'(o_bvalid[0]), 128'(1));
    chk(0, "rst_axim_bready", 128'(o_bready[0]), 128'(1));
    advance();
    rst = 1'b0; bv[0] = 1'b0;
    check_model();
    chk(0, "post_reset_level", 128'(o_level[0]), 128'(0));
    chk(0, "post_reset_valid", 128'(o_valid[0]), 128'(0));
    advance();

    // Randomised traffic on both instances against the queue model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) == 0);
      for (int d = 0; d < 2; d++) begin
        bv[d]    = 1'($urandom_range(1));
        br[d]    = 1'($urandom_range(3) != 0);
        rdy[d]   = 1'($urandom_range(2) == 0);
        bid[d]   = $urandom;
        bresp[d] = 2'($urandom_range(3));
        buser[d] = {$urandom, $urandom};
      end
      check_model();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
